pipelined_addsub: RTL

- Parametrised, pipelined ripple-carry adder/subtractor. Successor to the fixed 32-bit combinational carry-ripple adder.
- The WIDTH-bit carry chain is cut into STAGES equal segments, with the carry registered between segments. This raises Fmax for the Booth multiplier datapath and wider accumulators.
- Adds a runtime add/subtract mode and valid/ready flow control with backpressure.
- Sits between the Booth partial-product logic and the accumulator register.

---
 rtl/pipelined_addsub_if.sv | 29 ++
 rtl/pipelined_addsub.sv | 101 ++++++++++
 2 files changed

// File: rtl/pipelined_addsub_if.sv
// Flow-controlled operand/result bundle for pipelined_addsub.
//   master: drives in_valid, a, b, cin, sub, out_ready; observes in_ready,
//           out_valid, sum, cout, overflow.
//   slave : the adder side (inverse directions).
interface pipelined_addsub_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, overflow
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, overflow
    );
endinterface

// File: rtl/pipelined_addsub.sv
// Pipelined ripple-carry adder/subtractor. The WIDTH-bit carry chain is split
// into STAGES segments of SEG bits with the carry registered between them.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - pipelined_addsub_if.slave: in_valid/in_ready, a, b, cin, sub,
//           out_valid/out_ready, sum, cout, overflow
// sub=0 computes a+b+cin, sub=1 computes a+~b+1 (cin ignored). All stages
// advance together whenever the output register is empty or being drained.
module pipelined_addsub #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 4
) (
    input logic              clk,
    input logic              rst_n,
    pipelined_addsub_if.slave bus
);
    localparam int unsigned SEG = WIDTH / STAGES;
    localparam int unsigned L   = STAGES - 1;

    // Per-stage registers. Each stage carries full-width operand copies and
    // the partially built sum; stage k fills in bits [k*SEG +: SEG].
    logic             v_q [STAGES];
    logic [WIDTH-1:0] a_q [STAGES];
    logic [WIDTH-1:0] b_q [STAGES];
    logic [WIDTH-1:0] s_q [STAGES];
    logic             c_q [STAGES];
    logic             ov_q;

    // Next-state values for each stage.
    logic             n_v  [STAGES];
    logic [WIDTH-1:0] n_a  [STAGES];
    logic [WIDTH-1:0] n_b  [STAGES];
    logic [WIDTH-1:0] n_s  [STAGES];
    logic             n_ci [STAGES];
    logic             n_c  [STAGES];
    logic [SEG:0]     t    [STAGES];
    logic             ov_n;

    logic adv;

    assign adv          = !v_q[L] || bus.out_ready;
    assign bus.in_ready = adv;

    always_comb begin
        // Stage 0 sources come straight from the input beat.
        n_v[0]  = bus.in_valid;
        n_a[0]  = bus.a;
        n_b[0]  = bus.sub ? ~bus.b : bus.b;
        n_s[0]  = '0;
        n_ci[0] = bus.sub ? 1'b1 : bus.cin;
        for (int unsigned k = 1; k < STAGES; k++) begin
            n_v[k]  = v_q[k-1];
            n_a[k]  = a_q[k-1];
            n_b[k]  = b_q[k-1];
            n_s[k]  = s_q[k-1];
            n_ci[k] = c_q[k-1];
        end
        for (int unsigned k = 0; k < STAGES; k++) begin
            t[k] = {1'b0, n_a[k][k*SEG +: SEG]} + {1'b0, n_b[k][k*SEG +: SEG]}
                 + {{SEG{1'b0}}, n_ci[k]};
            n_s[k][k*SEG +: SEG] = t[k][SEG-1:0];
            n_c[k] = t[k][SEG];
        end
        ov_n = (n_a[L][WIDTH-1] == n_b[L][WIDTH-1]) &&
               (n_s[L][WIDTH-1] != n_a[L][WIDTH-1]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                v_q[k] <= 1'b0;
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
                c_q[k] <= 1'b0;
            end
            ov_q <= 1'b0;
        end else if (adv) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                v_q[k] <= n_v[k];
                // Bubbles move the valid bit only; data registers keep
                // their last contents.
                if (n_v[k]) begin
                    a_q[k] <= n_a[k];
                    b_q[k] <= n_b[k];
                    s_q[k] <= n_s[k];
                    c_q[k] <= n_c[k];
                end
            end
            if (n_v[L]) begin
                ov_q <= ov_n;
            end
        end
    end

    assign bus.out_valid = v_q[L];
    assign bus.sum       = s_q[L];
    assign bus.cout      = c_q[L];
    assign bus.overflow  = ov_q;
endmodule
